line_follow_ctrl: RTL and testbench
===================================

// Module: line_follow_ctrl
// PURPOSE
//  Parametrised line-following motion controller: classifies an N-bit IR/IP sensor
//  array, runs a timed drive FSM (forward, minimum-length turns, coast, search,
//  brake, lost-fault) and drives the H-bridge INs plus PWM enables. Sits between
//  the sensor front end and the H-bridge routing module; successor to the fixed
//  4-sensor forward block, adding turn hold timing, lost-line recovery, obstacle
//  brake and speed control.
// PARAMETERS
//  SENS_W      4     sensor count, even, >=2; bit 0 = rightmost sensor
//  CNT_W       16    width of state timer
//  TURN_MIN    4     minimum cycles held in a turn state before re-evaluation
//  COAST_CYC   8     cycles of inertial coast after line lost from FWD
//  SEARCH_CYC  64    cycles of search turn before declaring line lost
//  PWM_W       8     PWM counter width
//  FWD_DUTY    200   forward duty (enables high while pwm_cnt < duty)
//  TURN_DUTY   128   duty in TURN_L, TURN_R, SEARCH
// PORTS
//  clock       in   1        system clock, all logic on posedge
//  reset       in   1        synchronous, active-high
//  run_en      in   1        0 forces IDLE and clears fault
//  obstacle    in   1        1 = front obstacle, forces BRAKE
//  sens        in   SENS_W   raw sensor vector, 1 = line seen
//  h_bridge_ins out 4        INs: FWD 1001, REV 0110, R 0101, L 1010, HARD 1111, INERT 0000
//  enables     out  2        motor enables {left,right}
//  state_o     out  3        current FSM state encoding
//  fault       out  1        1 while in LOST
// BEHAVIOUR
//  - Reset: state IDLE, h_bridge_ins 0000, enables 00, fault 0, last_dir=RIGHT,
//    timer 0, pwm_cnt 0, sens_q 0.
//  - sens registered once into sens_q; FSM uses sens_q; outputs are Moore decodes of
//    the state register, registered -> sens change to h_bridge_ins change = 2 cycles.
//  - Classify sens_q: L=popcount(upper half), R=popcount(lower half).
//    sens_q==0 -> LOSTLINE; L==R (nonzero) -> CENTRE; L>R -> LEFT; R>L -> RIGHT.
//  - States: IDLE=0 FWD=1 TURN_L=2 TURN_R=3 COAST=4 SEARCH=5 BRAKE=6 LOST=7.
//  - Priority each cycle: reset > !run_en (->IDLE) > obstacle (->BRAKE, not from LOST)
//    > timed/sensor transitions.
//  - IDLE: INERT, enables 00; run_en=1 -> classify-dispatch.
//  - Dispatch: CENTRE->FWD, LEFT->TURN_L, RIGHT->TURN_R, LOSTLINE->COAST.
//  - FWD: dispatch every cycle (self-loop on CENTRE).
//  - TURN_L/TURN_R: entry sets last_dir; held >= TURN_MIN cycles (timer 0..TURN_MIN-1),
//    then dispatch each cycle; same-direction stays without timer restart.
//  - COAST: INERT, enables 00; any line seen -> dispatch; after COAST_CYC cycles
//    still lost -> SEARCH.
//  - SEARCH: turn toward last_dir; line seen -> dispatch; SEARCH_CYC cycles -> LOST.
//  - BRAKE: HARD 1111, enables 11 forced; obstacle low -> dispatch next cycle.
//  - LOST: HARD 1111, enables 11, fault=1; exits only via run_en=0 or reset.
//  - Timer clears to 0 on every state change, increments otherwise, saturates at max.
//  - pwm_cnt free-running PWM_W bits, wraps 2^PWM_W-1 -> 0; enables={2{pwm_cnt<duty}}
//    in FWD (FWD_DUTY) and turn/search states (TURN_DUTY).
//  - Reset or run_en drop mid-turn/search aborts immediately; no residual timer state.
// TESTING
//  - Reset held 3 cycles, sens=4'b0110 -> IDLE, INs 0000, enables 00, fault 0.
//  - run_en=1, sens=4'b0110 -> state FWD, INs 1001 two cycles later; enables high
//    200 of every 256 cycles.
//  - sens=4'b0011 for 1 cycle then 4'b0110 -> TURN_R held exactly 4 cycles, then FWD.
//  - From FWD, sens=0 forever -> COAST 8 cycles, SEARCH (INs 1010 if last turn was left)
//    64 cycles, then LOST with INs 1111, fault=1; run_en=0 -> IDLE, fault 0.
//  - obstacle=1 during TURN_L -> BRAKE next cycle, INs 1111 enables 11; release with
//    sens=4'b1111 -> FWD.
//  - sens=4'b1001 (L==R) -> FWD; reset asserted during SEARCH -> IDLE next cycle.

Source files
------------

// File: rtl/line_follow_ctrl.sv
// Line-following motion controller: classifies the sensor array and runs a timed
// drive FSM (forward, held turns, coast, search, brake, lost) onto H-bridge INs and PWM enables.
module line_follow_ctrl #(
    parameter int SENS_W     = 4,
    parameter int CNT_W      = 16,
    parameter int TURN_MIN   = 4,
    parameter int COAST_CYC  = 8,
    parameter int SEARCH_CYC = 64,
    parameter int PWM_W      = 8,
    parameter int FWD_DUTY   = 200,
    parameter int TURN_DUTY  = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_en,
    input  logic              obstacle,
    input  logic [SENS_W-1:0] sens,
    output logic [3:0]        h_bridge_ins,
    output logic [1:0]        enables,
    output logic [2:0]        state_o,
    output logic              fault
);

    localparam int HALF = SENS_W / 2;
    localparam int PC_W = $clog2(HALF + 1);

    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_MIN - 1);
    localparam logic [CNT_W-1:0] COAST_LAST  = CNT_W'(COAST_CYC - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_TURN_L = 3'd2,
        S_TURN_R = 3'd3,
        S_COAST  = 3'd4,
        S_SEARCH = 3'd5,
        S_BRAKE  = 3'd6,
        S_LOST   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        C_LOSTLINE = 2'd0,
        C_CENTRE   = 2'd1,
        C_LEFT     = 2'd2,
        C_RIGHT    = 2'd3
    } cls_e;

    state_e            state_q, state_d;
    state_e            disp_state;
    cls_e              cls;
    logic [SENS_W-1:0] sens_q;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [PWM_W-1:0]  pwm_cnt_q;
    logic              last_left_q, last_left_d;
    logic [PC_W-1:0]   l_cnt, r_cnt;
    logic              fwd_on, turn_on;

    // State register plus the timer, sensor stage, PWM counter and turn memory
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sens_q      <= '0;
            timer_q     <= '0;
            pwm_cnt_q   <= '0;
            last_left_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sens_q      <= sens;
            timer_q     <= timer_d;
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
            last_left_q <= last_left_d;
        end
    end

    always_comb begin
        l_cnt = '0;
        r_cnt = '0;
        for (int i = 0; i < HALF; i++) begin
            l_cnt = l_cnt + PC_W'(sens_q[HALF + i]);
            r_cnt = r_cnt + PC_W'(sens_q[i]);
        end
        if (sens_q == '0)        cls = C_LOSTLINE;
        else if (l_cnt == r_cnt) cls = C_CENTRE;
        else if (l_cnt > r_cnt)  cls = C_LEFT;
        else                     cls = C_RIGHT;

        case (cls)
            C_CENTRE: disp_state = S_FWD;
            C_LEFT:   disp_state = S_TURN_L;
            C_RIGHT:  disp_state = S_TURN_R;
            default:  disp_state = S_COAST;
        endcase
    end

    // Next state: run_en and obstacle override the timed/sensor transitions
    always_comb begin
        state_d = state_q;
        if (!run_en) begin
            state_d = S_IDLE;
        end else if (obstacle && state_q != S_LOST) begin
            state_d = S_BRAKE;
        end else begin
            case (state_q)
                S_IDLE, S_FWD, S_BRAKE: state_d = disp_state;
                S_TURN_L, S_TURN_R: begin
                    if (timer_q >= TURN_LAST) state_d = disp_state;
                end
                S_COAST: begin
                    if (cls != C_LOSTLINE)         state_d = disp_state;
                    else if (timer_q >= COAST_LAST) state_d = S_SEARCH;
                end
                S_SEARCH: begin
                    if (cls != C_LOSTLINE)          state_d = disp_state;
                    else if (timer_q >= SEARCH_LAST) state_d = S_LOST;
                end
                S_LOST:  state_d = S_LOST;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q)  timer_d = '0;
        else if (timer_q != '1)  timer_d = timer_q + 1'b1;
        else                     timer_d = timer_q;

        if (state_d == S_TURN_L)      last_left_d = 1'b1;
        else if (state_d == S_TURN_R) last_left_d = 1'b0;
        else                          last_left_d = last_left_q;
    end

    // Moore outputs decoded from the state register
    always_comb begin
        fwd_on       = pwm_cnt_q < PWM_W'(FWD_DUTY);
        turn_on      = pwm_cnt_q < PWM_W'(TURN_DUTY);
        h_bridge_ins = 4'b0000;
        enables      = 2'b00;
        fault        = 1'b0;
        state_o      = state_q;
        case (state_q)
            S_FWD: begin
                h_bridge_ins = 4'b1001;
                enables      = {2{fwd_on}};
            end
            S_TURN_L: begin
                h_bridge_ins = 4'b1010;
                enables      = {2{turn_on}};
            end
            S_TURN_R: begin
                h_bridge_ins = 4'b0101;
                enables      = {2{turn_on}};
            end
            S_SEARCH: begin
                h_bridge_ins = last_left_q ? 4'b1010 : 4'b0101;
                enables      = {2{turn_on}};
            end
            S_BRAKE: begin
                h_bridge_ins = 4'b1111;
                enables      = 2'b11;
            end
            S_LOST: begin
                h_bridge_ins = 4'b1111;
                enables      = 2'b11;
                fault        = 1'b1;
            end
            default: begin
                h_bridge_ins = 4'b0000;
                enables      = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: directed sensor/control sequences push expected
// {state, INs, enables, fault} words that a negedge monitor pops and compares.
module tb_line_follow_ctrl;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FWD    = 3'd1;
    localparam logic [2:0] ST_TURN_L = 3'd2;
    localparam logic [2:0] ST_TURN_R = 3'd3;
    localparam logic [2:0] ST_COAST  = 3'd4;
    localparam logic [2:0] ST_SEARCH = 3'd5;
    localparam logic [2:0] ST_BRAKE  = 3'd6;
    localparam logic [2:0] ST_LOST   = 3'd7;

    logic       clock;
    logic       reset;
    logic       run_en;
    logic       obstacle;
    logic [3:0] sens;
    logic [3:0] h_bridge_ins;
    logic [1:0] enables;
    logic [2:0] state_o;
    logic       fault;

    logic [9:0] exp_q[$];
    string      name_q[$];
    int         sc_exp_q[$];
    int         sc_act_q[$];
    string      sc_name_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_pwm;

    line_follow_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .run_en      (run_en),
        .obstacle    (obstacle),
        .sens        (sens),
        .h_bridge_ins(h_bridge_ins),
        .enables     (enables),
        .state_o     (state_o),
        .fault       (fault)
    );

    // Clock and reference PWM counter
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) m_pwm <= 8'd0;
        else       m_pwm <= m_pwm + 8'd1;
    end

    function automatic logic [1:0] pwm_en(input int duty);
        return (int'(m_pwm) < duty) ? 2'b11 : 2'b00;
    endfunction

    // Driver tasks
    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic [3:0] ins,
                       input logic [1:0] en, input logic flt);
        exp_q.push_back({st, ins, en, flt});
        name_q.push_back(nm);
    endtask

    task automatic chk_scalar(input string nm, input int act, input int expv);
        sc_act_q.push_back(act);
        sc_exp_q.push_back(expv);
        sc_name_q.push_back(nm);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        logic [9:0] e;
        logic [9:0] a;
        string      n;
        int         ea;
        int         ee;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {state_o, h_bridge_ins, enables, fault};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got state=%0d ins=%b en=%b fault=%b, expected state=%0d ins=%b en=%b fault=%b",
                         n, a[9:7], a[6:3], a[2:1], a[0], e[9:7], e[6:3], e[2:1], e[0]);
            end
        end
        while (sc_exp_q.size() > 0) begin
            ea = sc_act_q.pop_front();
            ee = sc_exp_q.pop_front();
            n  = sc_name_q.pop_front();
            checks++;
            if (ea != ee) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", n, ea, ee);
            end
        end
    end

    initial begin
        int hi;
        int lo;
        reset    = 1'b1;
        run_en   = 1'b0;
        obstacle = 1'b0;
        sens     = 4'b0110;
        repeat (3) step();
        chk("reset_state", ST_IDLE, 4'b0000, 2'b00, 1'b0);
        reset = 1'b0;
        step();
        run_en = 1'b1;
        step();
        chk("fwd_entry", ST_FWD, 4'b1001, pwm_en(200), 1'b0);
        step();
        chk("fwd_hold", ST_FWD, 4'b1001, pwm_en(200), 1'b0);

        // Forward duty over one full PWM period
        hi = 0;
        lo = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (enables == 2'b11)      hi++;
            else if (enables == 2'b00) lo++;
        end
        chk_scalar("fwd_duty_high", hi, 200);
        chk_scalar("fwd_duty_low", lo, 56);

        // One-cycle right pulse: TURN_R held exactly TURN_MIN cycles
        sens = 4'b0011;
        step();
        sens = 4'b0110;
        step();
        chk("turn_r_entry", ST_TURN_R, 4'b0101, pwm_en(128), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("turn_r_hold", ST_TURN_R, 4'b0101, pwm_en(128), 1'b0);
        end
        step();
        chk("turn_r_exit", ST_FWD, 4'b1001, pwm_en(200), 1'b0);

        // Left turn, back to FWD, then lose the line for good
        sens = 4'b1100;
        step();
        sens = 4'b0110;
        step();
        chk("turn_l_entry", ST_TURN_L, 4'b1010, pwm_en(128), 1'b0);
        repeat (4) step();
        chk("turn_l_exit", ST_FWD, 4'b1001, pwm_en(200), 1'b0);
        sens = 4'b0000;
        step();
        chk("lost_latency", ST_FWD, 4'b1001, pwm_en(200), 1'b0);
        step();
        chk("coast_entry", ST_COAST, 4'b0000, 2'b00, 1'b0);
        repeat (7) step();
        chk("coast_last", ST_COAST, 4'b0000, 2'b00, 1'b0);
        step();
        chk("search_left", ST_SEARCH, 4'b1010, pwm_en(128), 1'b0);
        repeat (63) step();
        chk("search_last", ST_SEARCH, 4'b1010, pwm_en(128), 1'b0);
        step();
        chk("lost_entry", ST_LOST, 4'b1111, 2'b11, 1'b1);
        repeat (6) step();
        chk("lost_sticky", ST_LOST, 4'b1111, 2'b11, 1'b1);
        run_en = 1'b0;
        step();
        chk("lost_clear", ST_IDLE, 4'b0000, 2'b00, 1'b0);

        // Obstacle during TURN_L, released with all sensors lit
        sens = 4'b1100;
        step();
        run_en = 1'b1;
        step();
        chk("obst_turn_l", ST_TURN_L, 4'b1010, pwm_en(128), 1'b0);
        sens     = 4'b1111;
        obstacle = 1'b1;
        step();
        chk("brake_entry", ST_BRAKE, 4'b1111, 2'b11, 1'b0);
        step();
        chk("brake_hold", ST_BRAKE, 4'b1111, 2'b11, 1'b0);
        obstacle = 1'b0;
        step();
        chk("brake_release", ST_FWD, 4'b1001, pwm_en(200), 1'b0);

        // Balanced outer sensors count as centre
        sens = 4'b0011;
        step();
        sens = 4'b1001;
        step();
        chk("turn_r_1001", ST_TURN_R, 4'b0101, pwm_en(128), 1'b0);
        repeat (4) step();
        chk("centre_1001", ST_FWD, 4'b1001, pwm_en(200), 1'b0);

        // Reset during SEARCH, then a full fresh coast
        sens = 4'b0000;
        repeat (10) step();
        chk("search_right", ST_SEARCH, 4'b0101, pwm_en(128), 1'b0);
        repeat (2) step();
        chk("search_mid", ST_SEARCH, 4'b0101, pwm_en(128), 1'b0);
        reset = 1'b1;
        step();
        chk("reset_abort", ST_IDLE, 4'b0000, 2'b00, 1'b0);
        reset = 1'b0;
        step();
        chk("coast_fresh", ST_COAST, 4'b0000, 2'b00, 1'b0);
        repeat (7) step();
        chk("coast_fresh_last", ST_COAST, 4'b0000, 2'b00, 1'b0);
        step();
        chk("search_fresh", ST_SEARCH, 4'b0101, pwm_en(128), 1'b0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
